// File: rtl/axi_sram_slave.sv
// Single-beat AXI3 slave backed by a word-organised SRAM.
// Independent read and write FSMs; one outstanding transaction per direction.
module axi_sram_slave #(
  parameter int ADDR_BITS = 12,
  parameter int RD_DELAY  = 1,
  parameter int WR_DELAY  = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  o_rd_state,
  output logic [1:0]  o_wr_state
);

  // Handshake rule on every channel: a transfer happens on the rising edge
  // where valid and ready are both 1; the sender holds payload stable while
  // valid=1 and ready=0, and valid never depends combinationally on ready.

  localparam logic [1:0] R_IDLE    = 2'd0;
  localparam logic [1:0] R_WAIT    = 2'd1;
  localparam logic [1:0] R_RESP    = 2'd2;
  localparam logic [1:0] W_COLLECT = 2'd0;
  localparam logic [1:0] W_WAIT    = 2'd1;
  localparam logic [1:0] W_RESP    = 2'd2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [31:0] r_mem [0:(2**ADDR_BITS)-1];

  // Read path state
  logic [1:0]           r_rstate;
  logic [3:0]           r_rcnt;
  logic [ADDR_BITS-1:0] r_ridx;
  logic [3:0]           r_arid;
  logic                 r_rerr;
  logic                 r_arready;
  logic                 r_rvalid;
  logic                 r_rlast;
  logic [3:0]           r_rid;
  logic [1:0]           r_rresp;
  logic [31:0]          r_rdata;

  // Write path state
  logic [1:0]           r_wstate;
  logic [3:0]           r_wcnt;
  logic                 r_aw_got;
  logic                 r_w_got;
  logic [ADDR_BITS-1:0] r_awidx;
  logic [3:0]           r_awid;
  logic                 r_awlen_ok;
  logic [3:0]           r_wid;
  logic [31:0]          r_wdata;
  logic [3:0]           r_wstrb;
  logic                 r_wlast;
  logic                 r_werr;
  logic                 r_awready;
  logic                 r_wready;
  logic                 r_bvalid;
  logic [3:0]           r_bid;
  logic [1:0]           r_bresp;

  logic w_commit;
  logic w_ok;
  logic w_unused;

  assign w_unused = ^{arsize, arburst, arlock, arcache, arprot,
                      awsize, awburst, awlock, awcache, awprot,
                      araddr[31:ADDR_BITS+2], araddr[1:0],
                      awaddr[31:ADDR_BITS+2], awaddr[1:0]};

  // Commit happens the edge after both AW and W are held.
  assign w_commit = (r_wstate == W_COLLECT) && r_aw_got && r_w_got;
  assign w_ok     = r_awlen_ok && (r_wid == r_awid) && r_wlast;

  always_ff @(posedge clk) begin
    if (w_commit && w_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (r_wstrb[i]) r_mem[r_awidx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rstate  <= R_IDLE;
      r_rcnt    <= 4'd0;
      r_ridx    <= '0;
      r_arid    <= 4'd0;
      r_rerr    <= 1'b0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rid     <= 4'd0;
      r_rresp   <= 2'b00;
      r_rdata   <= 32'd0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (arvalid && r_arready) begin
            r_arid    <= arid;
            r_ridx    <= araddr[ADDR_BITS+1:2];
            r_rerr    <= (arlen != 8'd0);
            r_arready <= 1'b0;
            r_rcnt    <= 4'(RD_DELAY);
            r_rstate  <= R_WAIT;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_WAIT: begin
          if (r_rcnt == 4'd0) begin
            r_rdata  <= r_mem[r_ridx];
            r_rid    <= r_arid;
            r_rresp  <= r_rerr ? RESP_SLVERR : RESP_OKAY;
            r_rlast  <= 1'b1;
            r_rvalid <= 1'b1;
            r_rstate <= R_RESP;
          end else begin
            r_rcnt <= r_rcnt - 4'd1;
          end
        end
        R_RESP: begin
          if (rready) begin
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wstate   <= W_COLLECT;
      r_wcnt     <= 4'd0;
      r_aw_got   <= 1'b0;
      r_w_got    <= 1'b0;
      r_awidx    <= '0;
      r_awid     <= 4'd0;
      r_awlen_ok <= 1'b0;
      r_wid      <= 4'd0;
      r_wdata    <= 32'd0;
      r_wstrb    <= 4'd0;
      r_wlast    <= 1'b0;
      r_werr     <= 1'b0;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bid      <= 4'd0;
      r_bresp    <= 2'b00;
    end else begin
      case (r_wstate)
        W_COLLECT: begin
          if (w_commit) begin
            r_werr   <= !w_ok;
            r_aw_got <= 1'b0;
            r_w_got  <= 1'b0;
            r_wcnt   <= 4'(WR_DELAY);
            r_wstate <= W_WAIT;
          end else begin
            if (awvalid && r_awready) begin
              r_awid     <= awid;
              r_awidx    <= awaddr[ADDR_BITS+1:2];
              r_awlen_ok <= (awlen == 8'd0);
              r_aw_got   <= 1'b1;
              r_awready  <= 1'b0;
            end else if (!r_aw_got) begin
              r_awready <= 1'b1;
            end
            if (wvalid && r_wready) begin
              r_wid    <= wid;
              r_wdata  <= wdata;
              r_wstrb  <= wstrb;
              r_wlast  <= wlast;
              r_w_got  <= 1'b1;
              r_wready <= 1'b0;
            end else if (!r_w_got) begin
              r_wready <= 1'b1;
            end
          end
        end
        W_WAIT: begin
          if (r_wcnt == 4'd0) begin
            r_bvalid <= 1'b1;
            r_bid    <= r_awid;
            r_bresp  <= r_werr ? RESP_SLVERR : RESP_OKAY;
            r_wstate <= W_RESP;
          end else begin
            r_wcnt <= r_wcnt - 4'd1;
          end
        end
        W_RESP: begin
          if (bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_wstate  <= W_COLLECT;
          end
        end
        default: r_wstate <= W_COLLECT;
      endcase
    end
  end

  assign arready    = r_arready;
  assign rid        = r_rid;
  assign rdata      = r_rdata;
  assign rresp      = r_rresp;
  assign rlast      = r_rlast;
  assign rvalid     = r_rvalid;
  assign awready    = r_awready;
  assign wready     = r_wready;
  assign bid        = r_bid;
  assign bresp      = r_bresp;
  assign bvalid     = r_bvalid;
  assign o_rd_state = r_rstate;
  assign o_wr_state = r_wstate;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: table of write/readback vectors plus
// hand-written sequences for ordering, back-pressure, errors and reset.
module tb_axi_sram_slave;

  logic        clk;
  logic        resetn;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [1:0]  rd_state;
  logic [1:0]  wr_state;

  int checks = 0;
  int errors = 0;

  axi_sram_slave #(.ADDR_BITS(12), .RD_DELAY(1), .WR_DELAY(1)) dut (
    .clk(clk), .resetn(resetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(3'd2), .arburst(2'b01),
    .arlock(2'b00), .arcache(4'd0), .arprot(3'd0), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(3'd2), .awburst(2'b01),
    .awlock(2'b00), .awcache(4'd0), .awprot(3'd0), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .o_rd_state(rd_state), .o_wr_state(wr_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver: one write transaction; aw_at/w_at are cycle offsets for each valid.
  task automatic do_write(input logic [3:0] t_awid, input logic [3:0] t_wid,
                          input logic [31:0] t_addr, input logic [31:0] t_data,
                          input logic [3:0] t_strb, input logic [7:0] t_len,
                          input logic t_last, input int aw_at, input int w_at,
                          input int bhold, input logic [1:0] exp_resp, input string tag);
    logic aw_done, w_done, aw_hs, w_hs;
    int cyc, n;
    aw_done = 1'b0; w_done = 1'b0; cyc = 0;
    awid = t_awid; awaddr = t_addr; awlen = t_len;
    wid = t_wid; wdata = t_data; wstrb = t_strb; wlast = t_last;
    while (!(aw_done && w_done) && cyc < 20) begin
      awvalid = !aw_done && (cyc >= aw_at);
      wvalid  = !w_done && (cyc >= w_at);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      tick;
      cyc++;
      if (aw_hs) aw_done = 1'b1;
      if (w_hs) w_done = 1'b1;
      if (aw_done) awvalid = 1'b0;
      if (w_done) wvalid = 1'b0;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk({tag, "_captured"}, {62'd0, aw_done, w_done}, 64'h3);
    chk({tag, "_rdy_low"}, {62'd0, awready, wready}, 64'h0);
    n = 0;
    while (!bvalid && n < 20) begin
      tick;
      n++;
    end
    chk({tag, "_b_latency"}, 64'(n), 64'd3);
    chk({tag, "_b_resp"}, {57'd0, bvalid, bid, bresp}, {57'd0, 1'b1, t_awid, exp_resp});
    for (int i = 0; i < bhold; i++) begin
      tick;
      chk({tag, "_b_hold"}, {55'd0, bvalid, bid, bresp, awready, wready},
          {55'd0, 1'b1, t_awid, exp_resp, 2'b00});
    end
    bready = 1'b1;
    tick;
    bready = 1'b0;
    chk({tag, "_b_done"}, {61'd0, bvalid, awready, wready}, 64'h3);
  endtask

  // Driver: one read; arvalid stays high through back-pressure when rhold>0.
  task automatic do_read(input logic [3:0] t_id, input logic [31:0] t_addr,
                         input logic [7:0] t_len, input int rhold,
                         input logic [31:0] exp_data, input logic [1:0] exp_resp,
                         input string tag);
    logic hs;
    int cyc, n;
    arid = t_id; araddr = t_addr; arlen = t_len; arvalid = 1'b1;
    hs = 1'b0; cyc = 0;
    while (!hs && cyc < 20) begin
      hs = arready;
      tick;
      cyc++;
    end
    arvalid = (rhold > 0);
    chk({tag, "_ar_hs"}, {63'd0, hs}, 64'd1);
    chk({tag, "_arready_low"}, {63'd0, arready}, 64'd0);
    n = 0;
    while (!rvalid && n < 20) begin
      tick;
      n++;
    end
    chk({tag, "_r_latency"}, 64'(n), 64'd2);
    chk({tag, "_r_beat"}, {24'd0, rvalid, rid, rresp, rlast, rdata},
        {24'd0, 1'b1, t_id, exp_resp, 1'b1, exp_data});
    for (int i = 0; i < rhold; i++) begin
      tick;
      chk({tag, "_r_hold"}, {23'd0, rvalid, rid, rresp, rlast, arready, rdata},
          {23'd0, 1'b1, t_id, exp_resp, 1'b1, 1'b0, exp_data});
    end
    arvalid = 1'b0;
    rready = 1'b1;
    tick;
    rready = 1'b0;
    chk({tag, "_r_done"}, {61'd0, rvalid, rlast, arready}, 64'h1);
    for (int i = 0; i < 2; i++) begin
      tick;
      chk({tag, "_no_extra_beat"}, {63'd0, rvalid}, 64'd0);
    end
  endtask

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_at;
    int          w_at;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [7];
  logic hs;
  int   cyc;

  initial begin
    // Directed vectors: word index = addr[13:2]; 0x4020 aliases 0x20.
    vecs[0] = '{32'h1C00_0010, 32'hDEAD_BEEF, 4'hF, 0, 2, 32'h1C00_0010, 32'hDEAD_BEEF};
    vecs[1] = '{32'h0000_0020, 32'h1122_3344, 4'hF, 0, 0, 32'h0000_0020, 32'h1122_3344};
    vecs[2] = '{32'h0000_0020, 32'hAABB_CCDD, 4'h5, 1, 0, 32'h0000_0020, 32'h11BB_33DD};
    vecs[3] = '{32'h0000_4020, 32'h0000_0000, 4'h0, 0, 0, 32'h0000_0020, 32'h11BB_33DD};
    vecs[4] = '{32'h0000_4020, 32'hCAFE_F00D, 4'hF, 0, 1, 32'h0000_0020, 32'hCAFE_F00D};
    vecs[5] = '{32'h0000_FFFC, 32'h0123_4567, 4'hF, 2, 0, 32'h0000_FFFC, 32'h0123_4567};
    vecs[6] = '{32'h0000_FFFC, 32'hA500_0000, 4'h8, 0, 0, 32'h0000_FFFC, 32'hA523_4567};

    resetn = 1'b0;
    arid = 4'd0; araddr = 32'd0; arlen = 8'd0; arvalid = 1'b0; rready = 1'b0;
    awid = 4'd0; awaddr = 32'd0; awlen = 8'd0; awvalid = 1'b0;
    wid = 4'd0; wdata = 32'd0; wstrb = 4'd0; wlast = 1'b1; wvalid = 1'b0; bready = 1'b0;

    repeat (3) tick;
    chk("reset_outputs", {18'd0, arready, rid, rresp, rlast, rvalid, awready, wready,
                          bid, bresp, bvalid, rd_state, wr_state}, 64'd0);
    chk("reset_rdata", {32'd0, rdata}, 64'd0);
    resetn = 1'b1;
    #1;
    chk("readies_before_edge", {61'd0, arready, awready, wready}, 64'd0);
    tick;
    chk("readies_after_release", {61'd0, arready, awready, wready}, 64'h7);

    for (int i = 0; i < 7; i++) begin
      do_write(4'd1, 4'd1, vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb, 8'd0, 1'b1,
               vecs[i].aw_at, vecs[i].w_at, 0, 2'b00, $sformatf("vec%0d_w", i));
      do_read(4'd1, vecs[i].raddr, 8'd0, 0, vecs[i].exp, 2'b00, $sformatf("vec%0d_r", i));
    end

    // W ahead of AW with a long-stalled B channel
    do_write(4'd1, 4'd1, 32'h0000_0100, 32'h55AA_55AA, 4'hF, 8'd0, 1'b1, 2, 0, 5,
             2'b00, "w_first_bstall");
    do_read(4'd0, 32'h1C00_0010, 8'd0, 0, 32'hDEAD_BEEF, 2'b00, "ifetch_id0");

    // Error responses
    do_read(4'd1, 32'h0000_0100, 8'd3, 0, 32'h55AA_55AA, 2'b10, "arlen3");
    do_write(4'd1, 4'd0, 32'h0000_0100, 32'h0BAD_0BAD, 4'hF, 8'd0, 1'b1, 0, 0, 0,
             2'b10, "wid_mismatch");
    do_read(4'd1, 32'h0000_0100, 8'd0, 0, 32'h55AA_55AA, 2'b00, "after_wid_err");
    do_write(4'd1, 4'd1, 32'h0000_0100, 32'h0BAD_0BAD, 4'hF, 8'd1, 1'b1, 1, 0, 0,
             2'b10, "awlen1");
    do_read(4'd1, 32'h0000_0100, 8'd0, 0, 32'h55AA_55AA, 2'b00, "after_awlen_err");
    do_write(4'd1, 4'd1, 32'h0000_0100, 32'h0BAD_0BAD, 4'hF, 8'd0, 1'b0, 0, 0, 0,
             2'b10, "wlast0");

    // Read back-pressure with arvalid held high
    do_read(4'd1, 32'h0000_0100, 8'd0, 4, 32'h55AA_55AA, 2'b00, "rstall");

    // Reset asserted while the read sits in R_WAIT
    arid = 4'd1; araddr = 32'h0000_0020; arlen = 8'd0; arvalid = 1'b1;
    hs = 1'b0; cyc = 0;
    while (!hs && cyc < 20) begin
      hs = arready;
      tick;
      cyc++;
    end
    arvalid = 1'b0;
    chk("rst_mid_ar_hs", {63'd0, hs}, 64'd1);
    chk("rst_mid_in_wait", {62'd0, rd_state}, 64'd1);
    resetn = 1'b0;
    #1;
    chk("rst_mid_immediate", {59'd0, rvalid, arready, awready, wready, rlast}, 64'd0);
    tick;
    tick;
    chk("rst_mid_held", {60'd0, rvalid, arready, rd_state}, 64'd0);
    resetn = 1'b1;
    tick;
    chk("rst_mid_arready_back", {62'd0, arready, rvalid}, 64'h2);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("rst_mid_no_stray_beat", {63'd0, rvalid}, 64'd0);
    end
    do_read(4'd1, 32'h0000_0020, 8'd0, 0, 32'hCAFE_F00D, 2'b00, "rst_mid_retained");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
